wb_commit_unit: RTL

//  Write-back/commit stage of the 16-bit pipelined CPU; consumes the fields leaving the MEM/WB pipeline register.

---
 rtl/wb_commit_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: result select with LLB/LHB merge, registered register-file write,
// forwarding tap, retire counter and halt drain FSM. Optional macro WB_BYPASS_EN: same-cycle fwd_* bypass.
module wb_commit_unit #(
    parameter int DATA_W       = 16,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic              wb_RegWrite,
    input  logic              wb_MemtoReg,
    input  logic [3:0]        wb_Opcode,
    input  logic [3:0]        wb_RegRd,
    input  logic [DATA_W-1:0] wb_RegRsVal,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic [DATA_W-1:0] wb_lw_data,
    input  logic [DATA_W-1:0] wb_pc_inc,
    input  logic [7:0]        wb_imm8,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_valid,
    output logic [3:0]        fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic              halt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [3:0] OP_LLB = 4'b1010;
    localparam logic [3:0] OP_LHB = 4'b1011;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    function automatic logic [DATA_W-1:0] selectResult(
        input logic              memtoReg,
        input logic [3:0]        opcode,
        input logic [DATA_W-1:0] rsVal,
        input logic [DATA_W-1:0] aluData,
        input logic [DATA_W-1:0] lwData,
        input logic [DATA_W-1:0] pcInc,
        input logic [7:0]        imm8
    );
        logic [DATA_W-1:0] res;
        if (memtoReg)
            res = lwData;
        else if (opcode == OP_PCS)
            res = pcInc;
        else if (opcode == OP_LLB)
            res = {rsVal[DATA_W-1:8], imm8};
        else if (opcode == OP_LHB)
            res = {imm8, rsVal[DATA_W-9:0]};
        else
            res = aluData;
        return res;
    endfunction

    logic [1:0]        state;
    logic [DCNT_W-1:0] drainCnt;
    logic              accept_p0;
    logic              isHlt_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] result_p0;
    logic              vld_p1;
    logic [3:0]        waddr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [CNT_W-1:0]  retire_p1;

    // p0: qualify the incoming MEM/WB slot and select its result
    assign accept_p0 = (state == RUN) && wb_valid;
    assign isHlt_p0  = (wb_Opcode == OP_HLT);
    assign vld_p0    = accept_p0 && wb_RegWrite && (wb_RegRd != 4'd0) && !isHlt_p0;
    assign result_p0 = selectResult(wb_MemtoReg, wb_Opcode, wb_RegRsVal,
                                    wb_alu_data, wb_lw_data, wb_pc_inc, wb_imm8);

    // p1: registered register-file write port and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            waddr_p1  <= '0;
            wdata_p1  <= '0;
            retire_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                waddr_p1 <= wb_RegRd;
                wdata_p1 <= result_p0;
            end
            if (accept_p0)
                retire_p1 <= retire_p1 + CNT_W'(1);
        end
    end

    // Halt FSM: the drain counter runs out before HALTED becomes sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (accept_p0 && isHlt_p0) begin
                        state    <= DRAIN;
                        drainCnt <= DCNT_W'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0)
                        state <= HALTED;
                    else
                        drainCnt <= drainCnt - DCNT_W'(1);
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    assign rf_we      = vld_p1;
    assign rf_waddr   = waddr_p1;
    assign rf_wdata   = wdata_p1;
    assign retire_cnt = retire_p1;
    assign halt       = (state == HALTED);

`ifdef WB_BYPASS_EN
    assign fwd_valid = vld_p0;
    assign fwd_reg   = wb_RegRd;
    assign fwd_data  = result_p0;
`else
    assign fwd_valid = vld_p1;
    assign fwd_reg   = waddr_p1;
    assign fwd_data  = wdata_p1;
`endif

endmodule
